// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, axis phase type and output payload for the VGA raster generator.
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned CNT_RANGE = 1 << CNT_W;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam logic        VGA_SYNC_POL = 1'b0;

   localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_e;

   // Last count value of each phase; the phase FSM leaves a phase on that count.
   typedef struct packed {
      logic [CNT_W-1:0] act_last;
      logic [CNT_W-1:0] fp_last;
      logic [CNT_W-1:0] sync_last;
      logic [CNT_W-1:0] tot_last;
   } axis_lim_t;

   typedef struct packed {
      logic [CNT_W-1:0] x_pixel;
      logic [CNT_W-1:0] y_pixel;
      logic             data_enable;
      logic             vga_hs;
      logic             vga_vs;
      logic             line_start;
      logic             frame_start;
   } vga_out_t;

   function automatic axis_lim_t axis_limits(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
      axis_lim_t lim;
      lim.act_last  = CNT_W'(act - 1);
      lim.fp_last   = CNT_W'(act + fp - 1);
      lim.sync_last = CNT_W'(act + fp + sync - 1);
      lim.tot_last  = CNT_W'(act + fp + sync + bp - 1);
      return lim;
   endfunction

   localparam axis_lim_t VGA_H_LIM = axis_limits(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam axis_lim_t VGA_V_LIM = axis_limits(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator (master) and the pixel stage (slave).
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic             pixel_ce;
   logic [CNT_W-1:0] x_pixel;
   logic [CNT_W-1:0] y_pixel;
   logic             data_enable;
   logic             VGAHS;
   logic             VGAVS;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  pixel_ce,
      output x_pixel, y_pixel, data_enable, VGAHS, VGAVS, line_start, frame_start
   );

   modport slave (
      output pixel_ce,
      input  x_pixel, y_pixel, data_enable, VGAHS, VGAVS, line_start, frame_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
   import vga_timing_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  axis_lim_t        lim,
   output logic [CNT_W-1:0] cnt,
   output phase_e           phase,
   output logic             wrap_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   phase_e           phase_q, phase_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= ACTIVE;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Phase advances on the last count of the current phase, in lockstep with the counter.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      wrap_c  = step && (cnt_q == lim.tot_last);
      if (step) begin
         cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
         case (phase_q)
            ACTIVE:  if (cnt_q == lim.act_last)  phase_d = FRONT;
            FRONT:   if (cnt_q == lim.fp_last)   phase_d = SYNC;
            SYNC:    if (cnt_q == lim.sync_last) phase_d = BACK;
            BACK:    if (cnt_q == lim.tot_last)  phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
   end

   assign cnt   = cnt_q;
   assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axis counters feeding one registered output stage.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        SYNC_POL = VGA_SYNC_POL
) (
   input logic              vga_clk,
   input logic              rst,
   vga_timing_gen_if.master vif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam axis_lim_t   H_LIM   = axis_limits(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam axis_lim_t   V_LIM   = axis_limits(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam vga_out_t OUT_RST = '{
      x_pixel:     '0,
      y_pixel:     '0,
      data_enable: 1'b0,
      vga_hs:      ~SYNC_POL,
      vga_vs:      ~SYNC_POL,
      line_start:  1'b0,
      frame_start: 1'b0
   };

   if (H_TOTAL > CNT_RANGE) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL %0d exceeds the counter range", H_TOTAL);
   end
   if (V_TOTAL > CNT_RANGE) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL %0d exceeds the counter range", V_TOTAL);
   end

   logic [CNT_W-1:0] h_cnt, v_cnt;
   phase_e           h_phase, v_phase;
   logic             h_wrap_c;
   logic             v_wrap_unused;

   vga_axis_counter u_h_axis (
      .clk    (vga_clk),
      .rst    (rst),
      .step   (vif.pixel_ce),
      .lim    (H_LIM),
      .cnt    (h_cnt),
      .phase  (h_phase),
      .wrap_c (h_wrap_c)
   );

   // Vertical axis steps once per completed line, so its phase only changes at h_cnt = 0.
   vga_axis_counter u_v_axis (
      .clk    (vga_clk),
      .rst    (rst),
      .step   (h_wrap_c),
      .lim    (V_LIM),
      .cnt    (v_cnt),
      .phase  (v_phase),
      .wrap_c (v_wrap_unused)
   );

   vga_out_t out_d, out_q;

   // Pulses are qualified by pixel_ce so a held pixel never repeats them.
   always_comb begin
      out_d             = OUT_RST;
      out_d.data_enable = (h_phase == ACTIVE) && (v_phase == ACTIVE);
      if (out_d.data_enable) begin
         out_d.x_pixel = h_cnt;
         out_d.y_pixel = v_cnt;
      end
      out_d.vga_hs      = (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      out_d.vga_vs      = (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      out_d.line_start  = vif.pixel_ce && (h_cnt == '0) && (v_phase == ACTIVE);
      out_d.frame_start = vif.pixel_ce && (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         out_q <= OUT_RST;
      end else begin
         out_q <= out_d;
      end
   end

   assign vif.x_pixel     = out_q.x_pixel;
   assign vif.y_pixel     = out_q.y_pixel;
   assign vif.data_enable = out_q.data_enable;
   assign vif.VGAHS       = out_q.vga_hs;
   assign vif.VGAVS       = out_q.vga_vs;
   assign vif.line_start  = out_q.line_start;
   assign vif.frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full 640x480 instance for line timing and a shrunken instance for frame-level timing.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } smp_t;

   typedef struct packed {
      int   h_act, h_fp, h_sync, h_bp;
      int   v_act, v_fp, v_sync, v_bp;
      logic pol;
   } cfg_t;

   typedef struct packed {
      int   tag;
      smp_t e;
   } item_t;

   localparam cfg_t CFG_F = '{h_act: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                              v_act: 480, v_fp: 10, v_sync: 2, v_bp: 33, pol: 1'b0};
   localparam cfg_t CFG_S = '{h_act: 8, h_fp: 2, h_sync: 3, h_bp: 3,
                              v_act: 4, v_fp: 1, v_sync: 2, v_bp: 2, pol: 1'b1};

   localparam int TAG_NONE = 0, TAG_RST = 1, TAG_B = 2, TAG_C = 3, TAG_MID = 4, TAG_E = 5;
   localparam int F_FS = 0, F_LS = 1, F_DE = 2, F_HS = 3, F_VS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if vif_f ();
   vga_timing_gen_if vif_s ();
   assign vif_f.pixel_ce = ce;
   assign vif_s.pixel_ce = ce;

   vga_timing_gen dut_f (.vga_clk(clk), .rst(rst), .vif(vif_f));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
   ) dut_s (.vga_clk(clk), .rst(rst), .vif(vif_s));

   int    n_chk = 0;
   int    n_fail = 0;
   int    n_print = 0;
   item_t q_f[$], q_s[$];
   smp_t  f_b[$], f_mid[$], s_b[$], s_c[$], s_mid[$], s_e[$];
   int    fh = 0, fv = 0, sh = 0, sv = 0;
   bit    stim_done = 1'b0;

   task automatic fail_line(input string msg);
      n_fail++;
      if (n_print < 40) $display("FAIL %s", msg);
      n_print++;
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) fail_line($sformatf("%s: got %0d, expected %0d", nm, act, exp));
   endtask

   task automatic chk_smp(input string nm, input smp_t act, input smp_t exp);
      n_chk++;
      if (act !== exp)
         fail_line($sformatf("%s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                   nm, act.x, act.y, act.de, act.hs, act.vs, act.ls, act.fs,
                   exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs));
   endtask

   // Reference: outputs from range compares on the current position, then advance the position.
   function automatic smp_t model(input cfg_t c, input logic r, input logic en, inout int h, inout int v);
      smp_t o;
      int   ht, vt;
      ht = c.h_act + c.h_fp + c.h_sync + c.h_bp;
      vt = c.v_act + c.v_fp + c.v_sync + c.v_bp;
      o = '0;
      if (r) begin
         o.hs = ~c.pol;
         o.vs = ~c.pol;
         h = 0;
         v = 0;
         return o;
      end
      o.de = (h < c.h_act) && (v < c.v_act);
      o.x  = o.de ? 10'(h) : 10'd0;
      o.y  = o.de ? 10'(v) : 10'd0;
      o.hs = (h >= c.h_act + c.h_fp && h < c.h_act + c.h_fp + c.h_sync) ? c.pol : ~c.pol;
      o.vs = (v >= c.v_act + c.v_fp && v < c.v_act + c.v_fp + c.v_sync) ? c.pol : ~c.pol;
      o.ls = en && (h == 0) && (v < c.v_act);
      o.fs = en && (h == 0) && (v == 0);
      if (en) begin
         if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
         end else begin
            h = h + 1;
         end
      end
      return o;
   endfunction

   function automatic phase_e phase_of(input int c, input int act, input int fp, input int sync);
      if (c < act) return ACTIVE;
      if (c < act + fp) return FRONT;
      if (c < act + fp + sync) return SYNC;
      return BACK;
   endfunction

   task automatic drive(input logic r, input logic en, input int tag);
      item_t it;
      @(negedge clk);
      rst = r;
      ce  = en;
      it.tag = tag;
      it.e   = model(CFG_F, r, en, fh, fv);
      q_f.push_back(it);
      it.e   = model(CFG_S, r, en, sh, sv);
      q_s.push_back(it);
   endtask

   function automatic logic fld(input smp_t o, input int sel);
      case (sel)
         F_FS:    return o.fs;
         F_LS:    return o.ls;
         F_DE:    return o.de;
         F_HS:    return o.hs;
         default: return o.vs;
      endcase
   endfunction

   function automatic int find(input smp_t s[$], input int from, input int sel, input logic val);
      if (from < 0) return -1;
      for (int i = from; i < s.size(); i++) if (fld(s[i], sel) === val) return i;
      return -1;
   endfunction

   function automatic int run_len(input smp_t s[$], input int from, input int sel, input logic val);
      int n = 0;
      if (from < 0) return -1;
      for (int i = from; i < s.size(); i++) begin
         if (fld(s[i], sel) !== val) break;
         n++;
      end
      return n;
   endfunction

   function automatic int count(input smp_t s[$], input int from, input int to, input int sel);
      int n = 0;
      if (from < 0 || to < 0) return -1;
      for (int i = from; i < to && i < s.size(); i++) if (fld(s[i], sel) === 1'b1) n++;
      return n;
   endfunction

   function automatic smp_t at(input smp_t s[$], input int i);
      if (i < 0 || i >= s.size()) return '1;
      return s[i];
   endfunction

   // Monitor: every clock the DUTs present an output; compare it with the queued expectation.
   initial begin
      item_t it;
      smp_t  act;
      forever begin
         @(posedge clk);
         #1;
         if (q_f.size() > 0) begin
            it  = q_f.pop_front();
            act = {vif_f.x_pixel, vif_f.y_pixel, vif_f.data_enable, vif_f.VGAHS, vif_f.VGAVS,
                   vif_f.line_start, vif_f.frame_start};
            chk_smp($sformatf("full_out tag%0d", it.tag), act, it.e);
            if (it.tag == TAG_B) f_b.push_back(act);
            if (it.tag == TAG_MID) f_mid.push_back(act);
         end
         if (q_s.size() > 0) begin
            it  = q_s.pop_front();
            act = {vif_s.x_pixel, vif_s.y_pixel, vif_s.data_enable, vif_s.VGAHS, vif_s.VGAVS,
                   vif_s.line_start, vif_s.frame_start};
            chk_smp($sformatf("small_out tag%0d", it.tag), act, it.e);
            chk_int("small_h_phase_vs_cnt", int'(dut_s.h_phase),
                    int'(phase_of(int'(dut_s.h_cnt), CFG_S.h_act, CFG_S.h_fp, CFG_S.h_sync)));
            chk_int("small_v_phase_vs_cnt", int'(dut_s.v_phase),
                    int'(phase_of(int'(dut_s.v_cnt), CFG_S.v_act, CFG_S.v_fp, CFG_S.v_sync)));
            case (it.tag)
               TAG_B:   s_b.push_back(act);
               TAG_C:   s_c.push_back(act);
               TAG_MID: s_mid.push_back(act);
               TAG_E:   s_e.push_back(act);
               default: ;
            endcase
         end
      end
   end

   // Stimulus: reset, free run, pixel_ce toggling, mid-frame reset.
   initial begin
      repeat (3) drive(1'b1, 1'b1, TAG_RST);
      repeat (1700) drive(1'b0, 1'b1, TAG_B);
      for (int i = 0; i < 700; i++) drive(1'b0, (i % 2) == 0, TAG_C);
      repeat (37) drive(1'b0, 1'b1, TAG_NONE);
      repeat (3) drive(1'b1, 1'b1, TAG_MID);
      repeat (200) drive(1'b0, 1'b1, TAG_E);
      stim_done = 1'b1;
   end

   initial begin
      int i0, i1, a, b, p;
      wait (stim_done);
      repeat (3) @(posedge clk);
      #2;
      chk_int("sb_drain_full", q_f.size(), 0);
      chk_int("sb_drain_small", q_s.size(), 0);

      // Full-size line timing after reset release.
      i0 = find(f_b, 0, F_FS, 1'b1);
      chk_int("full_first_fs_idx", i0, 0);
      chk_int("full_de_high_run", run_len(f_b, i0, F_DE, 1'b1), 640);
      chk_int("full_de_low_run", run_len(f_b, i0 + 640, F_DE, 1'b0), 160);
      chk_int("full_line_period", find(f_b, i0 + 1, F_LS, 1'b1) - i0, 800);
      chk_int("full_last_x_line0", int'(at(f_b, i0 + 639).x), 639);
      chk_int("full_y_line1", int'(at(f_b, i0 + 800).y), 1);
      p = find(f_b, i0, F_HS, 1'b0);
      chk_int("full_hs_offset", p - i0, 656);
      chk_int("full_hs_width", run_len(f_b, p, F_HS, 1'b0), 96);
      chk_int("full_vs_idle", find(f_b, 0, F_VS, 1'b0), -1);
      chk_int("full_mid_rst_de", int'(at(f_mid, 2).de), 0);
      chk_int("full_mid_rst_hs", int'(at(f_mid, 2).hs), 1);

      // Shrunken frame (16x9 totals, active-high syncs).
      i0 = find(s_b, 0, F_FS, 1'b1);
      i1 = find(s_b, i0 + 1, F_FS, 1'b1);
      chk_int("small_first_fs_idx", i0, 0);
      chk_int("small_frame_period", i1 - i0, 144);
      chk_int("small_de_count", count(s_b, i0, i1, F_DE), 32);
      chk_int("small_ls_count", count(s_b, i0, i1, F_LS), 4);
      chk_int("small_last_pix_x", int'(at(s_b, i0 + 55).x), 7);
      chk_int("small_last_pix_y", int'(at(s_b, i0 + 55).y), 3);
      chk_int("small_after_last_de", int'(at(s_b, i0 + 56).de), 0);
      chk_int("small_corner_pre_de", int'(at(s_b, i1 - 1).de), 0);
      chk_int("small_corner_vs", int'(at(s_b, i1).vs), 0);
      chk_int("small_corner_de", int'(at(s_b, i1).de), 1);
      p = find(s_b, i0, F_VS, 1'b1);
      chk_int("small_vs_offset", p - i0, 80);
      chk_int("small_vs_width", run_len(s_b, p, F_VS, 1'b1), 32);
      p = find(s_b, i0, F_HS, 1'b1);
      chk_int("small_hs_offset", p - i0, 10);
      chk_int("small_hs_width", run_len(s_b, p, F_HS, 1'b1), 3);

      // pixel_ce toggling: every pixel shown twice, pulses once.
      a = find(s_c, 1, F_FS, 1'b1);
      b = find(s_c, a + 1, F_FS, 1'b1);
      chk_int("toggle_frame_period", b - a, 288);
      chk_int("toggle_de_count", count(s_c, a, b, F_DE), 64);
      chk_int("toggle_ls_count", count(s_c, a, b, F_LS), 4);
      chk_int("toggle_line_period", find(s_c, a + 1, F_LS, 1'b1) - a, 32);
      chk_int("toggle_x_m1", int'(at(s_c, a - 1).x), 0);
      chk_int("toggle_de_m1", int'(at(s_c, a - 1).de), 1);
      chk_int("toggle_fs_m1", int'(at(s_c, a - 1).fs), 0);
      chk_int("toggle_x_p1", int'(at(s_c, a + 1).x), 1);
      chk_int("toggle_x_p2", int'(at(s_c, a + 2).x), 1);
      chk_int("toggle_x_p3", int'(at(s_c, a + 3).x), 2);

      // Mid-frame reset and release.
      chk_int("mid_rst_de", int'(at(s_mid, 2).de), 0);
      chk_int("mid_rst_vs", int'(at(s_mid, 2).vs), 0);
      chk_int("release_fs", int'(at(s_e, 0).fs), 1);
      chk_int("release_ls", int'(at(s_e, 0).ls), 1);
      chk_int("release_xy", int'({at(s_e, 0).x, at(s_e, 0).y}), 0);
      chk_int("release_de", int'(at(s_e, 0).de), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
